// File: rtl/rgb2gray_bram_loader_pkg.sv
`default_nettype none
// ============================================================================
// rgb2gray_bram_loader_pkg: loader FSM encoding and BT.601 luma constants
// Revision: 1.0
// ============================================================================
package rgb2gray_bram_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Weights sum to 256, so the weighted sum shifted by 8 stays within 8 bits.
    localparam int unsigned c_coef_r = 77;
    localparam int unsigned c_coef_g = 150;
    localparam int unsigned c_coef_b = 29;
    localparam int unsigned c_shift  = 8;
    localparam int unsigned c_round  = 1 << (c_shift - 1);

endpackage
`default_nettype wire

// File: rtl/rgb2gray_bram_loader_if.sv
`default_nettype none
// ============================================================================
// rgb2gray_bram_loader_if: RGB888 valid/ready pixel stream
// Revision: 1.0
// ============================================================================
interface rgb2gray_bram_loader_if
    import rgb2gray_bram_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
);
    logic                      s_valid;
    logic                      s_ready;
    logic [3*DATA_WIDTH-1:0]   s_data;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface
`default_nettype wire

// File: rtl/rgb2gray_bram_loader_pipe.sv
`default_nettype none
// ============================================================================
// rgb2gray_pipe: 2-stage RGB->luma multiply/sum with valid sideband.
// Macro RGB2GRAY_ROUND_EN selects round-to-nearest instead of truncation.
// Revision: 1.0
// ============================================================================
module rgb2gray_pipe
    import rgb2gray_bram_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    i_en,
    input  wire logic                    i_valid,
    input  wire logic [3*DATA_WIDTH-1:0] i_data,
    output logic                         o_v1,
    output logic                         o_valid,
    output logic [DATA_WIDTH-1:0]        o_y
);
    localparam int PW = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] w_r, w_g, w_b;
    logic [PW-1:0]         w_sum;
    logic [PW-1:0]         r_pr, r_pg, r_pb;
    logic                  r_v1, r_v2;
    logic [DATA_WIDTH-1:0] r_y;

    assign w_r = i_data[3*DATA_WIDTH-1:2*DATA_WIDTH];
    assign w_g = i_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_b = i_data[DATA_WIDTH-1:0];

`ifdef RGB2GRAY_ROUND_EN
    assign w_sum = r_pr + r_pg + r_pb + PW'(c_round);
`else
    assign w_sum = r_pr + r_pg + r_pb;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_pr <= '0;
            r_pg <= '0;
            r_pb <= '0;
            r_y  <= '0;
        end else if (i_en) begin
            r_v1 <= i_valid;
            r_v2 <= r_v1;
            if (i_valid) begin
                r_pr <= PW'(c_coef_r) * PW'(w_r);
                r_pg <= PW'(c_coef_g) * PW'(w_g);
                r_pb <= PW'(c_coef_b) * PW'(w_b);
            end
            if (r_v1) begin
                r_y <= w_sum[c_shift +: DATA_WIDTH];
            end
        end
    end

    assign o_v1    = r_v1;
    assign o_valid = r_v2;
    assign o_y     = r_y;
endmodule
`default_nettype wire

// File: rtl/rgb2gray_bram_loader.sv
`default_nettype none
// ============================================================================
// rgb2gray_bram_loader: streams RGB888 pixels to luma, fills the Sobel input
// BRAM from address 0 and pulses the Sobel run when the frame is written.
// Revision: 1.0
// ============================================================================
module rgb2gray_bram_loader
    import rgb2gray_bram_loader_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 100,
    parameter int IMAGE_HEIGHT = 100
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  i_en,
    input  wire logic                  i_run,
    input  wire logic [ADDR_WIDTH-1:0] i_num_cnt,
    rgb2gray_bram_loader_if.slave      s_if,
    output logic                       o_ce,
    output logic                       o_we,
    output logic [ADDR_WIDTH-1:0]      o_addr,
    output logic [DATA_WIDTH-1:0]      o_d,
    output logic                       o_sobel_run,
    output logic                       o_idle,
    output logic                       o_busy,
    output logic                       o_done
);
    if (longint'(IMAGE_WIDTH) * longint'(IMAGE_HEIGHT) > (longint'(1) << ADDR_WIDTH)) begin : g_size_check
        $error("rgb2gray_bram_loader: image does not fit the BRAM address space");
    end

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_num;
    logic [ADDR_WIDTH-1:0] r_acc_cnt;
    logic [ADDR_WIDTH-1:0] r_wr_addr;

    logic                  w_ready;
    logic                  w_xfer;
    logic                  w_v1;
    logic                  w_v2;
    logic [DATA_WIDTH-1:0] w_y;

    assign w_ready = rst_n && i_en && (r_state == ST_LOAD) && (r_acc_cnt < r_num);
    assign w_xfer  = w_ready && s_if.s_valid;

    assign s_if.s_ready = w_ready;

    rgb2gray_pipe #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (i_en),
        .i_valid (w_xfer),
        .i_data  (s_if.s_data),
        .o_v1    (w_v1),
        .o_valid (w_v2),
        .o_y     (w_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_num     <= '0;
            r_acc_cnt <= '0;
            r_wr_addr <= '0;
        end else if (i_en) begin
            if (w_v2) begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_run) begin
                        r_num     <= i_num_cnt;
                        r_acc_cnt <= '0;
                        r_wr_addr <= '0;
                        r_state   <= (i_num_cnt == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        r_acc_cnt <= r_acc_cnt + 1'b1;
                        if (ADDR_WIDTH'(r_acc_cnt + 1'b1) == r_num) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Stage-2 entry retires on this same edge, so only stage 1 gates the exit.
                    if (!w_v1) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ce        = rst_n && i_en && w_v2;
    assign o_we        = rst_n && i_en && w_v2;
    assign o_addr      = r_wr_addr;
    assign o_d         = w_y;
    assign o_idle      = (r_state == ST_IDLE);
    assign o_busy      = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
    assign o_done      = (r_state == ST_DONE);
    assign o_sobel_run = (r_state == ST_DONE);
endmodule
`default_nettype wire
